// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for pipe_stage_skid: upstream side, downstream side and perf counters.
// slave = the stage itself; master = whoever drives the stage inputs.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        out_level;
   logic [31:0]       out_stall_cnt;
   logic [31:0]       out_bubble_cnt;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, out_level,
             out_stall_cnt, out_bubble_cnt
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, out_level,
             out_stall_cnt, out_bubble_cnt
   );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline boundary register with a 2-entry skid buffer, flush and bubble masking of control bits.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters; otherwise they read 0.
//
//  state | meaning
//  EMPTY | no entry held, out_valid=0
//  ONE   | head (main) register valid
//  TWO   | main and skid valid, in_ready=0
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 6
) (
   input logic               in_clk,
   input logic               in_rst,
   input logic               in_flush,
   pipe_stage_skid_if.slave  bus
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic              in_ready_q, in_ready_d;
   logic              accept, emit, out_valid;

   assign out_valid = (state_q != EMPTY);
   assign accept    = bus.in_valid & in_ready_q;
   assign emit      = out_valid & bus.out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d     = ONE;
               main_data_d = bus.in_data;
               main_ctrl_d = bus.in_ctrl;
            end
         end
         ONE: begin
            if (accept && emit) begin
               main_data_d = bus.in_data;
               main_ctrl_d = bus.in_ctrl;
            end else if (accept) begin
               state_d     = TWO;
               skid_data_d = bus.in_data;
               skid_ctrl_d = bus.in_ctrl;
            end else if (emit) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (emit) begin
               state_d     = ONE;
               main_data_d = skid_data_q;
               main_ctrl_d = skid_ctrl_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Squashed transfers never reach the data registers; they just keep their old contents.
      if (in_flush) begin
         state_d     = EMPTY;
         main_data_d = main_data_q;
         main_ctrl_d = main_ctrl_q;
         skid_data_d = skid_data_q;
         skid_ctrl_d = skid_ctrl_q;
      end
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = main_data_q;
   assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
   assign bus.out_level = state_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q, bubble_cnt_q;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (out_valid && !bus.out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (!out_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign bus.out_stall_cnt  = stall_cnt_q;
   assign bus.out_bubble_cnt = bubble_cnt_q;
`else
   assign bus.out_stall_cnt  = 32'h0;
   assign bus.out_bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed test-plan steps followed by random traffic, all checked against a queue model.
module tb_pipe_stage_skid;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 6;

   typedef struct packed {
      logic [CTRL_W-1:0] c;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic clk, rst, flush;
   int   checks, errors;

   pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .in_clk  (clk),
      .in_rst  (rst),
      .in_flush(flush),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model: a FIFO of at most two entries plus a registered ready flag
   ent_t              q[$];
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [31:0]       m_stall, m_bubble;

   task automatic model_update();
      logic acc, emt;
      if (rst) begin
         q.delete();
         m_ready  = 1'b1;
         m_data   = '0;
         m_stall  = '0;
         m_bubble = '0;
      end else begin
         acc = bus.in_valid & m_ready;
         emt = (q.size() > 0) & bus.out_ready;
         if (q.size() > 0 && !bus.out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (q.size() == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
         if (flush) begin
            q.delete();
         end else begin
            if (emt) void'(q.pop_front());
            if (acc) q.push_back('{c: bus.in_ctrl, d: bus.in_data});
         end
         m_ready = (q.size() < 2);
         if (q.size() > 0) m_data = q[0].d;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [31:0] es, eb;
`ifdef PIPE_STAGE_PERF_EN
      es = m_stall;
      eb = m_bubble;
`else
      es = 32'h0;
      eb = 32'h0;
`endif
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("in_ready",  64'(bus.in_ready),  64'(m_ready));
      chk("out_level", 64'(bus.out_level), 64'(q.size()));
      chk("out_data",  64'(bus.out_data),  64'(m_data));
      chk("out_ctrl",  64'(bus.out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'h0);
      chk("stall_cnt", 64'(bus.out_stall_cnt),  64'(es));
      chk("bubble_cnt", 64'(bus.out_bubble_cnt), 64'(eb));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic ordy);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_ctrl   = c;
      bus.out_ready = ordy;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      q.delete();
      m_ready = 1'b1; m_data = '0; m_stall = '0; m_bubble = '0;
      rst = 1'b1; flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      step();
      chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      rst = 1'b0;

      // streaming
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, DATA_W'(i), 6'h05, 1'b1);
         step();
         chk("stream_data", 64'(bus.out_data), 64'(i));
         chk("stream_ready", 64'(bus.in_ready), 64'h1);
      end
      drive(1'b0, '0, '0, 1'b1);
      step();

      // backpressure
      drive(1'b1, 32'hA, 6'h01, 1'b0);
      step();
      drive(1'b1, 32'hB, 6'h02, 1'b0);
      step();
      chk("bp_level", 64'(bus.out_level), 64'h2);
      chk("bp_ready", 64'(bus.in_ready), 64'h0);
      chk("bp_head", 64'(bus.out_data), 64'hA);
      drive(1'b0, '0, '0, 1'b0);
      step();
      chk("bp_hold", 64'(bus.out_data), 64'hA);
      drive(1'b0, '0, '0, 1'b1);
      step();
      chk("bp_second", 64'(bus.out_data), 64'hB);
      chk("bp_ready_back", 64'(bus.in_ready), 64'h1);
      step();

      // bubble masking
      drive(1'b1, 32'h77, 6'h3F, 1'b1);
      step();
      chk("mask_valid_ctrl", 64'(bus.out_ctrl), 64'h3F);
      drive(1'b0, 32'h78, 6'h3F, 1'b1);
      step();
      chk("mask_bubble_ctrl", 64'(bus.out_ctrl), 64'h0);
      chk("mask_bubble_valid", 64'(bus.out_valid), 64'h0);

      // flush with level 2 and a simultaneous accept attempt
      drive(1'b1, 32'h11, 6'h01, 1'b0); step();
      drive(1'b1, 32'h22, 6'h02, 1'b0); step();
      flush = 1'b1;
      drive(1'b1, 32'h33, 6'h03, 1'b1);
      step();
      flush = 1'b0;
      chk("flush_valid", 64'(bus.out_valid), 64'h0);
      chk("flush_level", 64'(bus.out_level), 64'h0);
      chk("flush_ready", 64'(bus.in_ready), 64'h1);
      drive(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush_no_33", 64'(bus.out_data == 32'h33), 64'h0);
      end

      // stalls and bubbles for the perf counters, then reset mid-operation
      drive(1'b1, 32'h44, 6'h04, 1'b0); step();
      drive(1'b1, 32'h55, 6'h05, 1'b0); step();
      drive(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1; #2; rst = 1'b0;
      step();
      chk("async_pulse_level", 64'(bus.out_level), 64'h2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_level", 64'(bus.out_level), 64'h0);
      chk("midrst_data", 64'(bus.out_data), 64'h0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom(), CTRL_W'($urandom()),
               1'($urandom_range(0, 2) != 0));
         flush = ($urandom_range(0, 29) == 0);
         rst   = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0; flush = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
